// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_load_ctrl_pkg;

  localparam int          DEF_ADDR_W    = 9;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// Assembles four MSB-first bytes into a 32-bit word; the completed word is
// presented combinationally alongside the strobe of its fourth byte.
module imem_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  r_cnt;
  logic [31:0] r_shift;
  logic [31:0] w_word;

  assign w_word     = {r_shift[23:0], byte_data};
  assign word       = w_word;
  assign word_valid = byte_valid && (r_cnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'h0;
    end else if (clear) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'h0;
    end else if (byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= w_word;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner: UART program loader during a load session,
// fetch-stage read path with stall-hold while running.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [31:0]       fetch_addr,
  input  logic              fetch_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instruction,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow_err
);

  state_t r_state, w_state_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_word_count;
  logic              r_ovf;
  logic [31:0]       r_hold;

  logic        w_in_load;
  logic        w_start_load;
  logic        w_drop_partial;
  logic        w_byte_valid;
  logic [31:0] w_word;
  logic        w_word_valid;
  logic        w_is_halt;
  logic        w_full;
  logic        w_unused_bits;

  assign w_in_load    = (r_state == S_LOAD);
  assign w_byte_valid = rx_valid && w_in_load;
  assign w_is_halt    = (w_word == HALT_WORD);
  assign w_full       = r_word_count[ADDR_W];
  assign w_unused_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_start_load || w_drop_partial),
    .byte_valid (w_byte_valid),
    .byte_data  (rx_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_start_load   = 1'b0;
    w_drop_partial = 1'b0;
    cpu_hold       = 1'b1;
    instruction    = NOP_WORD;
    mem_addr       = r_wr_addr;
    mem_we         = 1'b0;
    load_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_next = S_LOAD;
          w_start_load = 1'b1;
        end
      end
      S_LOAD: begin
        mem_we = r_we;
        if (w_word_valid && (w_is_halt || w_full)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        load_done      = 1'b1;
        w_drop_partial = 1'b1;
        w_state_next   = S_RUN;
      end
      S_RUN: begin
        cpu_hold    = 1'b0;
        mem_addr    = fetch_addr[ADDR_W+1:2];
        instruction = fetch_stall ? r_hold : mem_rdata;
        if (load_start) begin
          w_state_next = S_LOAD;
          w_start_load = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A word can only complete four strobes after the previous one, so the
  // pending write always retires before the next full check looks at the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_wr_addr    <= '0;
      r_wdata      <= 32'h0;
      r_word_count <= '0;
      r_ovf        <= 1'b0;
      r_hold       <= 32'h0;
    end else begin
      r_we <= 1'b0;
      if (w_start_load) begin
        r_word_count <= '0;
        r_ovf        <= 1'b0;
      end else if (w_in_load) begin
        if (r_we) begin
          r_word_count <= r_word_count + (ADDR_W+1)'(1);
        end
        if (w_word_valid && !w_is_halt) begin
          if (!w_full) begin
            r_we      <= 1'b1;
            r_wr_addr <= r_word_count[ADDR_W-1:0];
            r_wdata   <= w_word;
          end else begin
            r_ovf <= 1'b1;
          end
        end
      end
      if (r_state == S_RUN && !fetch_stall) begin
        r_hold <= mem_rdata;
      end
    end
  end

  assign mem_wdata    = r_wdata;
  assign word_count   = r_word_count;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural 512-word memory.
module tb_imem_load_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [7:0]    rx_data = 8'h0;
  logic          rx_valid = 1'b0;
  logic [31:0]   fetch_addr = 32'h0;
  logic          fetch_stall = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic [31:0]   instruction;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          overflow_err;

  int tests = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit bad_wr = 1'b0;
  logic [31:0] mem [512];

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .instruction(instruction), .cpu_hold(cpu_hold),
    .load_done(load_done), .word_count(word_count), .overflow_err(overflow_err)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt = wr_cnt + 1;
      if (mem_wdata == 32'h1000_0200) bad_wr = 1'b1;
    end
    if (load_done) done_cnt = done_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: hold=%b done=%b we=%b exp 1 0 0", cpu_hold, load_done, mem_we); end
    tests++; if (mem_addr !== 9'd0 || mem_wdata !== 32'h0 || instruction !== 32'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h instr=%h exp 0 0 0", mem_addr, mem_wdata, instruction); end
    tests++; if (word_count !== 10'd0 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: wc=%0d ovf=%b exp 0 0", word_count, overflow_err); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL idle_hold: got %b exp 1", cpu_hold); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_idle_ignored();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    tests++; if (wr_cnt !== 0 || word_count !== 10'd0 || cpu_hold !== 1'b1 || instruction !== 32'h0) begin
      errors++; $display("FAIL idle_ignored: wr=%0d wc=%0d hold=%b instr=%h exp 0 0 1 0", wr_cnt, word_count, cpu_hold, instruction); end
    $display("[TB] test_idle_ignored done");
  endtask

  task automatic test_basic();
    pulse_start();
    tests++; if (cpu_hold !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL basic_load_entry: hold=%b we=%b exp 1 0", cpu_hold, mem_we); end
    send_byte(8'h02); send_byte(8'h53); send_byte(8'h88); send_byte(8'h20);
    tests++; if (mem_we !== 1'b1 || mem_addr !== 9'd0 || mem_wdata !== 32'h0253_8820 || word_count !== 10'd0) begin
      errors++; $display("FAIL basic_wr0: we=%b addr=%0d wdata=%h wc=%0d exp 1 0 02538820 0", mem_we, mem_addr, mem_wdata, word_count); end
    @(negedge clk);
    tests++; if (mem_we !== 1'b0 || word_count !== 10'd1) begin
      errors++; $display("FAIL basic_wc1: we=%b wc=%0d exp 0 1", mem_we, word_count); end
    send_byte(8'h00); send_byte(8'hA6); send_byte(8'h20); send_byte(8'h20);
    tests++; if (mem_we !== 1'b1 || mem_addr !== 9'd1 || mem_wdata !== 32'h00A6_2020) begin
      errors++; $display("FAIL basic_wr1: we=%b addr=%0d wdata=%h exp 1 1 00a62020", mem_we, mem_addr, mem_wdata); end
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    tests++; if (load_done !== 1'b1 || cpu_hold !== 1'b1 || word_count !== 10'd2) begin
      errors++; $display("FAIL basic_done: done=%b hold=%b wc=%0d exp 1 1 2", load_done, cpu_hold, word_count); end
    @(negedge clk);
    tests++; if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL basic_run: done=%b hold=%b exp 0 0", load_done, cpu_hold); end
    tests++; if (done_cnt !== 1 || wr_cnt !== 2 || mem[0] !== 32'h0253_8820 || mem[1] !== 32'h00A6_2020) begin
      errors++; $display("FAIL basic_mem: pulses=%0d writes=%0d m0=%h m1=%h exp 1 2 02538820 00a62020", done_cnt, wr_cnt, mem[0], mem[1]); end
    fetch_addr = 32'd4;
    #1;
    tests++; if (instruction !== 32'h00A6_2020) begin
      errors++; $display("FAIL basic_fetch4: got %h exp 00a62020", instruction); end
    $display("[TB] test_basic done");
  endtask

  task automatic test_stall();
    @(negedge clk);
    fetch_addr = 32'd0; fetch_stall = 1'b0;
    #1;
    tests++; if (instruction !== 32'h0253_8820) begin
      errors++; $display("FAIL stall_pre: got %h exp 02538820", instruction); end
    @(negedge clk);
    fetch_stall = 1'b1; fetch_addr = 32'd4;
    #1;
    tests++; if (instruction !== 32'h0253_8820) begin
      errors++; $display("FAIL stall_hold: got %h exp 02538820", instruction); end
    @(negedge clk);
    tests++; if (instruction !== 32'h0253_8820) begin
      errors++; $display("FAIL stall_hold2: got %h exp 02538820", instruction); end
    fetch_stall = 1'b0;
    #1;
    tests++; if (instruction !== 32'h00A6_2020) begin
      errors++; $display("FAIL stall_release: got %h exp 00a62020", instruction); end
    $display("[TB] test_stall done");
  endtask

  task automatic test_run_ignored();
    int wr0;
    wr0 = wr_cnt;
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    tests++; if (wr_cnt !== wr0 || word_count !== 10'd2 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL run_ignored: wr=%0d wc=%0d hold=%b exp %0d 2 0", wr_cnt, word_count, cpu_hold, wr0); end
    $display("[TB] test_run_ignored done");
  endtask

  task automatic test_reload();
    int wr0;
    wr0 = wr_cnt;
    pulse_start();
    tests++; if (cpu_hold !== 1'b1 || word_count !== 10'd0) begin
      errors++; $display("FAIL reload_hold: hold=%b wc=%0d exp 1 0", cpu_hold, word_count); end
    send_byte(8'h03);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h00; load_start = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; load_start = 1'b0;
    send_byte(8'h00); send_byte(8'h08);
    tests++; if (mem_we !== 1'b1 || mem_addr !== 9'd0 || mem_wdata !== 32'h0300_0008) begin
      errors++; $display("FAIL reload_wr: we=%b addr=%0d wdata=%h exp 1 0 03000008", mem_we, mem_addr, mem_wdata); end
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    @(negedge clk);
    tests++; if (word_count !== 10'd1 || wr_cnt !== wr0 + 1 || mem[0] !== 32'h0300_0008 || mem[1] !== 32'h00A6_2020) begin
      errors++; $display("FAIL reload_mem: wc=%0d writes=%0d m0=%h m1=%h exp 1 %0d 03000008 00a62020", word_count, wr_cnt - wr0, mem[0], mem[1], 1); end
    $display("[TB] test_reload done");
  endtask

  task automatic test_overflow();
    int wr0;
    int dn0;
    logic [31:0] w;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 513; i++) begin
      w = 32'h1000_0000 + i;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = w[31-8*b -: 8];
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    tests++; if (load_done !== 1'b1 || overflow_err !== 1'b1 || word_count !== 10'd512) begin
      errors++; $display("FAIL ovf_done: done=%b ovf=%b wc=%0d exp 1 1 512", load_done, overflow_err, word_count); end
    tests++; if (wr_cnt - wr0 !== 512 || bad_wr !== 1'b0 || mem[0] !== 32'h1000_0000 || mem[511] !== 32'h1000_01FF) begin
      errors++; $display("FAIL ovf_mem: writes=%0d bad=%b m0=%h m511=%h exp 512 0 10000000 100001ff", wr_cnt - wr0, bad_wr, mem[0], mem[511]); end
    @(negedge clk);
    tests++; if (done_cnt - dn0 !== 1 || overflow_err !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky: pulses=%0d ovf=%b hold=%b exp 1 1 0", done_cnt - dn0, overflow_err, cpu_hold); end
    $display("[TB] test_overflow done");
  endtask

  task automatic test_partial_reset();
    int wr0;
    pulse_start();
    tests++; if (overflow_err !== 1'b0 || word_count !== 10'd0) begin
      errors++; $display("FAIL partial_clear: ovf=%b wc=%0d exp 0 0", overflow_err, word_count); end
    wr0 = wr_cnt;
    send_byte(8'h01); send_byte(8'h02);
    reset = 1'b1;
    #1;
    tests++; if (cpu_hold !== 1'b1 || word_count !== 10'd0 || load_done !== 1'b0 || mem_we !== 1'b0 || instruction !== 32'h0) begin
      errors++; $display("FAIL partial_async: hold=%b wc=%0d done=%b we=%b instr=%h exp 1 0 0 0 0", cpu_hold, word_count, load_done, mem_we, instruction); end
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h03); send_byte(8'h04);
    tests++; if (cpu_hold !== 1'b1 || wr_cnt !== wr0 || word_count !== 10'd0 || mem[0] !== 32'h1000_0000) begin
      errors++; $display("FAIL partial_idle: hold=%b writes=%0d wc=%0d m0=%h exp 1 0 0 10000000", cpu_hold, wr_cnt - wr0, word_count, mem[0]); end
    $display("[TB] test_partial_reset done");
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    test_reset();
    test_idle_ignored();
    test_basic();
    test_stall();
    test_run_ignored();
    test_reload();
    test_overflow();
    test_partial_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
